// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce and hex digit accumulator
module keypad_scan #(
  parameter int CLK_DIV  = 25_000,
  parameter int DEBOUNCE = 10
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] key_value
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DEB_N     = DW'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, DEB, HELD} state_t;

  state_t        state;
  logic [3:0]    col_s1, col_s2;
  logic [TW-1:0] tick_cnt;
  logic [1:0]    row_idx;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic [3:0]    cand;
  logic [DW-1:0] deb_cnt;

  logic       tick, scan_end;
  logic [2:0] row_hits, sum_hits;
  logic [1:0] row_col;
  logic [3:0] code_now;
  logic       cls_none, cls_single;

  assign tick     = (tick_cnt == TICK_LAST);
  assign scan_end = tick && (row_idx == 2'd3);

  // Per-row hit count on the synchronized (active-low) columns, merged with earlier rows.
  always_comb begin
    row_hits = 3'd0;
    row_col  = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_s2[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 2'(c);
      end
    end
    sum_hits   = {1'b0, acc_cnt} + row_hits;
    code_now   = (row_hits != 3'd0) ? {row_idx, row_col} : acc_code;
    cls_none   = (sum_hits == 3'd0);
    cls_single = (sum_hits == 3'd1);
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      row_idx   <= 2'd0;
      row_out   <= 4'b1110;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'd0;
      cand      <= 4'd0;
      deb_cnt   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      key_value <= 16'd0;
    end else begin
      key_valid <= 1'b0;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        row_idx <= row_idx + 2'd1;
        row_out <= ~(4'b0001 << (row_idx + 2'd1));
        if (!scan_end) begin
          acc_cnt  <= (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
          acc_code <= code_now;
        end else begin
          acc_cnt  <= 2'd0;
          acc_code <= 4'd0;
          case (state)
            IDLE: begin
              if (cls_single) begin
                cand    <= code_now;
                deb_cnt <= DW'(1);
                state   <= DEB;
              end
            end
            DEB: begin
              if (cls_single && code_now == cand) begin
                if (deb_cnt + DW'(1) >= DEB_N) begin
                  key_valid <= 1'b1;
                  key_code  <= cand;
                  key_held  <= 1'b1;
                  deb_cnt   <= '0;
                  state     <= HELD;
                  if (cand <= 4'd9)
                    key_value <= {key_value[11:0], cand};
                  else if (cand == 4'hC)
                    key_value <= 16'd0;
                end else begin
                  deb_cnt <= deb_cnt + DW'(1);
                end
              end else begin
                deb_cnt <= '0;
                state   <= IDLE;
              end
            end
            HELD: begin
              // Any activity restarts the release count: no rollover events.
              if (!cls_none) begin
                deb_cnt <= '0;
              end else if (deb_cnt + DW'(1) >= DEB_N) begin
                key_held <= 1'b0;
                deb_cnt  <= '0;
                state    <= IDLE;
              end else begin
                deb_cnt <= deb_cnt + DW'(1);
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan
module tb_keypad_scan;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] key_value;
  logic [15:0] keys;

  int total = 0;
  int passed = 0;
  int vcount = 0;
  int base;
  logic [3:0] last_code = 4'd0;
  logic [3:0] rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scan #(.CLK_DIV(4), .DEBOUNCE(3)) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .key_value(key_value)
  );

  always #10 clk_50M = ~clk_50M;

  // Keypad matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(negedge clk_50M) begin
    if (key_valid) begin
      vcount    = vcount + 1;
      last_code = key_code;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic scans(input int n);
    repeat (n * 16) @(posedge clk_50M);
    #1;
  endtask

  task automatic stroke(input int k);
    keys    = '0;
    keys[k] = 1'b1;
    scans(6);
    keys = '0;
    scans(6);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    rst = 1'b0;
  endtask

  initial begin
    bit seen, found;
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    rst = 1'b0;
    #1;
    check("rst_row_out", 16'(row_out), 16'(4'b1110));
    check("rst_key_code", 16'(key_code), 16'd0);
    check("rst_key_valid", 16'(key_valid), 16'd0);
    check("rst_key_held", 16'(key_held), 16'd0);
    check("rst_key_value", key_value, 16'd0);

    for (int i = 1; i <= 16; i++) begin
      @(posedge clk_50M);
      #1;
      check("row_cycle", 16'(row_out), 16'(rows[(i / 4) % 4]));
    end

    base = vcount;
    scans(50);
    check("idle_no_event", 16'(vcount - base), 16'd0);

    // key (1,2) = code 6
    base = vcount;
    keys[6] = 1'b1;
    scans(10);
    check("k6_events", 16'(vcount - base), 16'd1);
    check("k6_code", 16'(last_code), 16'd6);
    check("k6_value", key_value, 16'h0006);
    check("k6_held", 16'(key_held), 16'd1);
    keys = '0;
    scans(1);
    check("k6_held_early_release", 16'(key_held), 16'd1);
    scans(5);
    check("k6_released", 16'(key_held), 16'd0);
    check("k6_single_event", 16'(vcount - base), 16'd1);

    pulse_reset();
    base = vcount;
    for (int i = 0; i < 8; i++) begin
      keys[5] = 1'b1;
      scans(1);
      keys = '0;
      scans(1);
    end
    scans(4);
    check("bounce_no_event", 16'(vcount - base), 16'd0);
    check("bounce_value", key_value, 16'd0);

    base = vcount;
    for (int k = 1; k <= 5; k++) stroke(k);
    check("digits_events", 16'(vcount - base), 16'd5);
    check("digits_value", key_value, 16'h2345);
    check("digits_last_code", 16'(last_code), 16'd5);
    stroke(12);
    check("clear_value", key_value, 16'h0000);
    stroke(10);
    check("keyA_code", 16'(key_code), 16'hA);
    check("keyA_value", key_value, 16'h0000);

    base = vcount;
    keys[1] = 1'b1;
    keys[5] = 1'b1;
    scans(5);
    check("multi_no_event", 16'(vcount - base), 16'd0);
    keys[1] = 1'b0;
    scans(2);
    check("multi_release_wait", 16'(vcount - base), 16'd0);
    scans(2);
    check("multi_then_single", 16'(vcount - base), 16'd1);
    check("multi_then_code", 16'(last_code), 16'd5);
    keys = '0;
    scans(6);

    // Align to a scan boundary so key 7 sits in DEB with cnt=2 when reset hits.
    seen  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk_50M);
      #1;
      if (row_out == 4'b0111) seen = 1'b1;
      else if (seen && row_out == 4'b1110) found = 1'b1;
    end
    check("align_scan", 16'(found), 16'd1);
    base = vcount;
    keys[7] = 1'b1;
    scans(2);
    rst = 1'b1;
    #1;
    check("mid_rst_row_out", 16'(row_out), 16'(4'b1110));
    check("mid_rst_key_code", 16'(key_code), 16'd0);
    check("mid_rst_key_held", 16'(key_held), 16'd0);
    check("mid_rst_key_valid", 16'(key_valid), 16'd0);
    keys = '0;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    rst = 1'b0;
    scans(6);
    check("mid_rst_no_event", 16'(vcount - base), 16'd0);
    stroke(9);
    check("after_rst_events", 16'(vcount - base), 16'd1);
    check("after_rst_code", 16'(last_code), 16'd9);
    check("after_rst_value", key_value, 16'h0009);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix keypad scanner forming the input half of the keypad/display pair. It drives keypad rows one at a time and samples the columns, then debounces presses. Each accepted key produces a one-cycle event, and digit keys are accumulated into a 16-bit, 4-nibble value. `key_value` connects directly to the 16-bit value input of the multiplexed seven-segment display driver.

## Interface
- `CLK_DIV`, default 25_000: `clk_50M` cycles per scan tick (2 kHz tick, 2 ms full 4-row scan).
- `DEBOUNCE`, default 10: consecutive identical full scans needed to accept a press or a release (20 ms).
- `clk_50M`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `col_in`  in  4  keypad columns, active-low, externally pulled up, asynchronous to `clk_50M`.
- `row_out`  out  4  keypad row drive, active-low one-cold; exactly one bit is low at all times.
- `key_code`  out  4  code of the last accepted key, = row*4 + col; holds until the next accepted key.
- `key_valid`  out  1  one-cycle pulse when a key is accepted.
- `key_held`  out  1  high from acceptance until the debounced release.
- `key_value`  out  16  accumulated digit value, one hex nibble per digit, newest digit in [3:0].

## Operation
- Reset values:
  - `row_out`=4'b1110
  - `key_code`=0, `key_valid`=0, `key_held`=0, `key_value`=0
  - FSM=IDLE; tick counter, row index, debounce counter and scan accumulator all 0.
- `col_in` passes through a 2-flop synchronizer before use.
- Tick generator: the counter runs 0..CLK_DIV-1 and `tick` is high for one cycle when it wraps.
- Scan, on each tick:
  - Capture the synchronized columns for the row currently driven.
  - Advance the row index 0→1→2→3→0 and update `row_out` on the same edge. Row r is driven low as `row_out[r]`=0.
  - A pressed key reads as `col_in[c]`=0 while its row is driven.
- Full scan: ends at the tick that captures row 3 and yields one classification:
  - NONE: zero keys pressed.
  - SINGLE(code): exactly one key pressed.
  - MULTI: two or more keys pressed.
- FSM, evaluated only at full-scan end:
  - IDLE: SINGLE(k) → cand=k, cnt=1, go DEB. NONE or MULTI → stay.
  - DEB: SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE: pulse `key_valid`, `key_code`=cand, `key_held`=1, go HELD. Any other result → IDLE, cnt=0.
  - HELD: NONE → cnt+1 (cnt is cleared on entry). Any pressed key → cnt=0. When cnt reaches DEBOUNCE: `key_held`=0, go IDLE.
- `key_value` update, on the `key_valid` edge:
  - Code 0–9: `key_value` = {`key_value`[11:0], code}; the oldest nibble is discarded.
  - Code 0xC: `key_value`=0.
  - Codes 0xA, 0xB, 0xD, 0xE, 0xF: `key_code`/`key_valid` only; `key_value` unchanged.
- Boundary rules:
  - DEBOUNCE=1 accepts on the first SINGLE scan, i.e. IDLE→DEB→HELD over two consecutive scans.
  - Keys pressed or changed while HELD never produce events; a full debounced release is required first (no rollover).
  - MULTI never produces an event in any state.
  - Asynchronous reset in any state returns all outputs to their reset values immediately. No pulse is emitted for a press interrupted by reset.

## Timing
- Latency from the first full scan showing a stable SINGLE(k) to `key_valid`: DEBOUNCE scans, i.e. DEBOUNCE*4*CLK_DIV cycles plus the scan-end alignment.
- `key_valid`, `key_code`, `key_value` and the rise of `key_held` all change on the same `clk_50M` edge, at a full-scan-end tick. `key_valid` is low on the next edge.
- `row_out` is stable for CLK_DIV cycles per row. The column sample is taken at the end of that window, so synchronizer delay (2 cycles) is always covered.
- `key_held` falls at the scan-end tick of the DEBOUNCE-th consecutive NONE scan.

## Test plan
Bench uses CLK_DIV=4, DEBOUNCE=3 (full scan = 16 cycles) and a keypad model that pulls `col_in[c]` low when `row_out[r]`=0 and key (r,c) is pressed.
- Reset, no keys → all outputs at reset values; `row_out` cycles 1110,1101,1011,0111 every 4 cycles; no `key_valid` over 50 scans.
- Press (1,2) for 10 scans, then release → exactly one `key_valid`, `key_code`=6, `key_value`=16'h0006; `key_held` high until the 3rd empty scan after release.
- Bouncing key 5 (one scan pressed, one released, repeated 8×) → no `key_valid`, `key_value` stays 0.
- Keys 1,2,3,4,5 with full releases between → `key_value`=16'h2345; then key 0xC → 16'h0000; then key 0xA → `key_code`=0xA, `key_value` still 0.
- Keys 1 and 5 together for 5 scans → no event; release 1 with 5 still held → one `key_valid` with `key_code`=5, 3 scans later.
- Key 7 in DEB with cnt=2, assert `rst` for 3 cycles → outputs reset immediately, no pulse; after release, pressing 9 → `key_valid`, `key_value`=16'h0009.
